// File: rtl/regfile_sequencer.sv
// regfile_sequencer: serialises read / write / clear-all requests from
// decode/execute onto the register-file strobe interface. It returns read data
// or an acknowledge over a valid/ready response channel. Only one register-file
// operation is in flight at a time, because reads and writes share rf_num1.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | req_ready high, waiting for a request
// RD_ISSUE   | rf_get_enable high for one cycle, addresses from latched fields
// RD_CAPT    | register file presents data; it is captured at the ending edge
// WR_ISSUE   | rf_set_enable high for one cycle, rf_num1 / rf_set_val latched
// CLR_ISSUE  | rf_reset_enable high for one cycle
// RESP       | rsp_valid high; data and err held until rsp_ready
module regfile_sequencer #(
  parameter int WORD_SIZE     = 8,
  parameter int REG_ADDR_SIZE = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [REG_ADDR_SIZE-1:0] req_addr_a,
  input  logic [REG_ADDR_SIZE-1:0] req_addr_b,
  input  logic [WORD_SIZE-1:0]     req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WORD_SIZE-1:0]     rsp_data_a,
  output logic [WORD_SIZE-1:0]     rsp_data_b,
  output logic                     rsp_err,
  output logic [CNT_WIDTH-1:0]     txn_count,
  output logic [REG_ADDR_SIZE-1:0] rf_num1,
  output logic [REG_ADDR_SIZE-1:0] rf_num2,
  output logic [WORD_SIZE-1:0]     rf_set_val,
  output logic                     rf_get_enable,
  output logic                     rf_set_enable,
  output logic                     rf_reset_enable,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  input  logic [WORD_SIZE-1:0]     rf_out2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_CAPT,
    S_WR_ISSUE,
    S_CLR_ISSUE,
    S_RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  state_t                   r_state;
  logic                     r_req_ready;
  logic                     r_rsp_valid;
  logic                     r_rsp_err;
  logic [WORD_SIZE-1:0]     r_rsp_data_a;
  logic [WORD_SIZE-1:0]     r_rsp_data_b;
  logic [CNT_WIDTH-1:0]     r_txn_count;
  logic [REG_ADDR_SIZE-1:0] r_addr_a;
  logic [REG_ADDR_SIZE-1:0] r_addr_b;
  logic [WORD_SIZE-1:0]     r_wdata;
  logic                     r_get_en;
  logic                     r_set_en;
  logic                     r_clr_en;

  // Sequencer FSM. Every output is a register, so nothing on req_* or
  // rsp_ready reaches the rf_* pins combinationally. Strobes are loaded on
  // the edge that enters the issue state and self-clear one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data_a <= '0;
      r_rsp_data_b <= '0;
      r_txn_count  <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_wdata      <= '0;
      r_get_en     <= 1'b0;
      r_set_en     <= 1'b0;
      r_clr_en     <= 1'b0;
    end else begin
      r_get_en <= 1'b0;
      r_set_en <= 1'b0;
      r_clr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // req_ready rises on the first edge after reset release, so the
          // earliest accept is the edge after that.
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr_a    <= req_addr_a;
            r_addr_b    <= req_addr_b;
            r_wdata     <= req_wdata;
            case (req_op)
              OP_READ: begin
                r_state  <= S_RD_ISSUE;
                r_get_en <= 1'b1;
              end
              OP_WRITE: begin
                r_state  <= S_WR_ISSUE;
                r_set_en <= 1'b1;
              end
              OP_CLEAR: begin
                r_state  <= S_CLR_ISSUE;
                r_clr_en <= 1'b1;
              end
              default: begin
                // Illegal op: no register-file access, answer right away.
                r_state      <= S_RESP;
                r_rsp_valid  <= 1'b1;
                r_rsp_err    <= 1'b1;
                r_rsp_data_a <= '0;
                r_rsp_data_b <= '0;
              end
            endcase
          end
        end
        S_RD_ISSUE: begin
          r_state <= S_RD_CAPT;
        end
        S_RD_CAPT: begin
          r_state      <= S_RESP;
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_data_a <= rf_out1;
          r_rsp_data_b <= rf_out2;
        end
        S_WR_ISSUE, S_CLR_ISSUE: begin
          r_state      <= S_RESP;
          r_rsp_valid  <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_data_a <= '0;
          r_rsp_data_b <= '0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data_a <= '0;
            r_rsp_data_b <= '0;
            r_txn_count  <= r_txn_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready       = r_req_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_err         = r_rsp_err;
  assign rsp_data_a      = r_rsp_data_a;
  assign rsp_data_b      = r_rsp_data_b;
  assign txn_count       = r_txn_count;
  assign rf_num1         = r_addr_a;
  assign rf_num2         = r_addr_b;
  assign rf_set_val      = r_wdata;
  assign rf_get_enable   = r_get_en;
  assign rf_set_enable   = r_set_en;
  assign rf_reset_enable = r_clr_en;

endmodule
